// File: rtl/slice_check_ctrl_pkg.sv
// Shared definitions for the bit-slice reversal checker and its neighbours.
//   - state_t    : sequencer states
//   - DATA_W_DEF : default stimulus/response width
//   - LFSR_TAPS  : feedback taps of the 8-bit stimulus LFSR (bits 7,5,4,3)
//   - bitrev()   : reference reversal, out[k] = in[DATA_W_DEF-1-k]
package slice_check_ctrl_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic [DATA_W_DEF-1:0] bitrev(input logic [DATA_W_DEF-1:0] v);
    logic [DATA_W_DEF-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W_DEF; i++) begin
      r[i] = v[DATA_W_DEF-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/slice_check_ctrl_if.sv
// Control/status bus of the reversal checker plus its stimulus/response pair.
//   master : harness side (drives start/num_vectors/seed and the DUT response)
//   slave  : checker side (drives stimulus and run status/results)
interface slice_check_ctrl_if
  import slice_check_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_W  = 16,
  parameter int ERR_W  = 16
);

  logic              start;
  logic [NUM_W-1:0]  num_vectors;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] stim_o;
  logic [DATA_W-1:0] dut_i;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [NUM_W-1:0]  first_err_idx;
  logic [DATA_W-1:0] first_err_in;
  logic [DATA_W-1:0] first_err_out;

  modport master (
    output start, num_vectors, seed, dut_i,
    input  stim_o, busy, done, pass, err_count,
           first_err_idx, first_err_in, first_err_out
  );

  modport slave (
    input  start, num_vectors, seed, dut_i,
    output stim_o, busy, done, pass, err_count,
           first_err_idx, first_err_in, first_err_out
  );

endinterface

// File: rtl/slice_check_ctrl_lfsr.sv
// Fibonacci LFSR stimulus source for the reversal checker.
//   clk, rst : clock, asynchronous active-high reset (value returns to 1)
//   load     : load seed (a zero seed is replaced by 1 so the LFSR never locks up)
//   seed     : seed value
//   advance  : shift one step: value <= {value[W-2:0], ^(value & TAPS)}
//   value    : current LFSR state
module slice_check_ctrl_lfsr
  import slice_check_ctrl_pkg::*;
#(
  parameter int           W    = DATA_W_DEF,
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         advance,
  output logic [W-1:0] value
);

  logic [W-1:0] value_reg;
  logic [W-1:0] value_next;
  logic         feedback;

  assign feedback = ^(value_reg & TAPS);

  always_comb begin
    value_next = value_reg;
    if (load) begin
      value_next = (seed == '0) ? W'(1) : seed;
    end else if (advance) begin
      value_next = {value_reg[W-2:0], feedback};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg <= W'(1);
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/slice_check_ctrl.sv
// Self-checking sequencer for the bit-slice reversal datapath.
// Drives LFSR vectors on stim_o, waits SETTLE cycles, then compares dut_i
// against the bit-reversed stimulus, counting (saturating) mismatches and
// capturing the first one of the run.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of slice_check_ctrl_if
//              (start/num_vectors/seed/dut_i in; stim_o/busy/done/pass/
//               err_count/first_err_idx/first_err_in/first_err_out out)
// Timing: accepted start -> LOAD (1 cycle), then per vector DRIVE (1),
// SETTLE (SETTLE), CHECK (1); done rises 1 + num*(SETTLE+2) cycles after start.
module slice_check_ctrl
  import slice_check_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_W  = 16,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  slice_check_ctrl_if.slave bus
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state_reg, state_next;
  logic [NUM_W-1:0]  num_reg;
  logic [NUM_W-1:0]  idx_reg;
  logic [CNT_W-1:0]  settle_cnt_reg;
  logic [DATA_W-1:0] stim_reg;
  logic [ERR_W-1:0]  err_reg;
  logic [NUM_W-1:0]  first_idx_reg;
  logic [DATA_W-1:0] first_in_reg;
  logic [DATA_W-1:0] first_out_reg;

  logic              start_accept;
  logic              lfsr_adv;
  logic [DATA_W-1:0] lfsr_value;
  logic [DATA_W-1:0] stim_rev;
  logic              mismatch;
  logic              last_vec;

  slice_check_ctrl_lfsr #(
    .W    (DATA_W),
    .TAPS (DATA_W'(LFSR_TAPS))
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_accept),
    .seed    (bus.seed),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  // Expected DUT response: plain rewiring of the held stimulus.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign stim_rev[gi] = stim_reg[DATA_W-1-gi];
    end
  endgenerate

  assign mismatch = (bus.dut_i != stim_rev);
  assign last_vec = ((idx_reg + NUM_W'(1)) == num_reg);

  // Next-state logic. Start is only honoured once the state register
  // actually reads IDLE or DONE, so a start in the cycle DONE is entered is lost.
  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    lfsr_adv     = 1'b0;
    unique case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_next   = ST_LOAD;
          start_accept = 1'b1;
        end
      end
      ST_LOAD:   state_next = (num_reg == '0) ? ST_DONE : ST_DRIVE;
      ST_DRIVE: begin
        state_next = ST_SETTLE;
        lfsr_adv   = 1'b1;
      end
      ST_SETTLE: begin
        if (settle_cnt_reg == '0) begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK:  state_next = last_vec ? ST_DONE : ST_DRIVE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Run parameters, counters and first-mismatch capture. Everything is
  // latched/cleared on the accepting edge so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_reg        <= '0;
      idx_reg        <= '0;
      settle_cnt_reg <= '0;
      stim_reg       <= '0;
      err_reg        <= '0;
      first_idx_reg  <= '0;
      first_in_reg   <= '0;
      first_out_reg  <= '0;
    end else begin
      if (start_accept) begin
        num_reg       <= bus.num_vectors;
        idx_reg       <= '0;
        err_reg       <= '0;
        first_idx_reg <= '0;
        first_in_reg  <= '0;
        first_out_reg <= '0;
      end

      if (state_reg == ST_DRIVE) begin
        stim_reg       <= lfsr_value;
        settle_cnt_reg <= CNT_W'(SETTLE - 1);
      end else if ((state_reg == ST_SETTLE) && (settle_cnt_reg != '0)) begin
        settle_cnt_reg <= settle_cnt_reg - CNT_W'(1);
      end

      if (state_reg == ST_CHECK) begin
        idx_reg <= idx_reg + NUM_W'(1);
        if (mismatch) begin
          if (err_reg != '1) begin
            err_reg <= err_reg + ERR_W'(1);
          end
          // err_count saturates and never returns to zero within a run,
          // so zero reliably marks "no mismatch captured yet".
          if (err_reg == '0) begin
            first_idx_reg <= idx_reg;
            first_in_reg  <= stim_reg;
            first_out_reg <= bus.dut_i;
          end
        end
      end
    end
  end

  assign bus.stim_o        = stim_reg;
  assign bus.busy          = (state_reg inside {ST_LOAD, ST_DRIVE, ST_SETTLE, ST_CHECK});
  assign bus.done          = (state_reg == ST_DONE);
  assign bus.pass          = (state_reg == ST_DONE) && (err_reg == '0);
  assign bus.err_count     = err_reg;
  assign bus.first_err_idx = first_idx_reg;
  assign bus.first_err_in  = first_in_reg;
  assign bus.first_err_out = first_out_reg;

endmodule

// File: tb/tb_slice_check_ctrl.sv
// Directed bench for slice_check_ctrl: an 8/16/16 instance with a
// selectable DUT model, and an ERR_W=2 instance facing an always-wrong DUT.
module tb_slice_check_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;     // 0: ideal reverser, 1: DUT input bit 0 stuck-at-0
  int   n_checks = 0;
  int   n_pass = 0;

  // Hand-computed LFSR sequence from seed 8'h01.
  logic [7:0] exp_seq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11,
                               8'h23, 8'h47, 8'h8E, 8'h1C, 8'h38};

  always #5 clk = ~clk;

  slice_check_ctrl_if #(.DATA_W(8), .NUM_W(16), .ERR_W(16)) bus ();
  slice_check_ctrl_if #(.DATA_W(8), .NUM_W(16), .ERR_W(2))  bus_s ();

  slice_check_ctrl #(.DATA_W(8), .NUM_W(16), .SETTLE(2), .ERR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  slice_check_ctrl #(.DATA_W(8), .NUM_W(16), .SETTLE(2), .ERR_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  always_comb begin
    if (mode == 1) bus.dut_i = rev8(bus.stim_o & 8'hFE);
    else           bus.dut_i = rev8(bus.stim_o);
  end
  always_comb bus_s.dut_i = ~rev8(bus_s.stim_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Pulse start across one rising edge; returns 1 ns after the accepting edge.
  task automatic pulse_start(input logic [15:0] n, input logic [7:0] s);
    bus.num_vectors = n;
    bus.seed        = s;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.num_vectors = 16'hFFFF;   // later changes must not affect the run
    bus.seed        = 8'hA5;
  endtask

  // Follows a run already started: checks every driven vector and the
  // exact cycle at which done rises (1 + num*4 edges after start).
  task automatic run_vectors(input int num, input string tag);
    for (int c = 1; c <= 1 + num * 4; c++) begin
      tick();
      if (c >= 2 && ((c - 2) % 4) == 0)
        chk({tag, "_stim"}, bus.stim_o, exp_seq[(c - 2) / 4]);
      if (c == num * 4) chk({tag, "_done_early"}, bus.done, 1'b0);
    end
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_busy_off"}, bus.busy, 1'b0);
    $display("run %s: num=%0d err=%0d pass=%0d first_idx=%0d in=%02h out=%02h",
             tag, num, bus.err_count, bus.pass, bus.first_err_idx,
             bus.first_err_in, bus.first_err_out);
  endtask

  initial begin
    bus.start = 1'b0;   bus.num_vectors = '0;   bus.seed = '0;
    bus_s.start = 1'b0; bus_s.num_vectors = '0; bus_s.seed = '0;

    // Reset state
    tick();
    chk("rst_stim", bus.stim_o, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_pass", bus.pass, 1'b0);
    chk("rst_err", bus.err_count, 16'h0);
    chk("rst_sat_done", bus_s.done, 1'b0);
    rst = 1'b0;
    tick();

    // Test 3: num=0 -> busy for exactly the LOAD cycle, then done/pass, stim untouched
    pulse_start(16'd0, 8'h5A);
    chk("t3_busy", bus.busy, 1'b1);
    chk("t3_done_early", bus.done, 1'b0);
    tick();
    chk("t3_done", bus.done, 1'b1);
    chk("t3_busy_off", bus.busy, 1'b0);
    chk("t3_pass", bus.pass, 1'b1);
    chk("t3_stim", bus.stim_o, 8'h00);
    $display("run t3: num=0 done=%0d pass=%0d", bus.done, bus.pass);

    // Test 1: ideal DUT, seed 01, 5 vectors
    mode = 0;
    pulse_start(16'd5, 8'h01);
    run_vectors(5, "t1");
    chk("t1_pass", bus.pass, 1'b1);
    chk("t1_err", bus.err_count, 16'd0);
    chk("t1_last_stim", bus.stim_o, 8'h11);

    // Test 2: DUT input bit 0 stuck-at-0 -> only vector 0 (01) mismatches
    mode = 1;
    pulse_start(16'd4, 8'h01);
    run_vectors(4, "t2");
    chk("t2_err", bus.err_count, 16'd1);
    chk("t2_pass", bus.pass, 1'b0);
    chk("t2_first_idx", bus.first_err_idx, 16'd0);
    chk("t2_first_in", bus.first_err_in, 8'h01);
    chk("t2_first_out", bus.first_err_out, 8'h00);

    // Test 4: seed 00 -> 01; start during SETTLE and at DONE entry ignored
    mode = 0;
    pulse_start(16'd3, 8'h00);
    chk("t4_err_cleared", bus.err_count, 16'd0);
    for (int c = 1; c <= 13; c++) begin
      tick();
      bus.start = 1'b0;
      if (c == 2) begin
        chk("t4_stim0", bus.stim_o, 8'h01);
        bus.start = 1'b1;          // lands on an edge spent in SETTLE
      end
      if (c == 6)  chk("t4_stim1", bus.stim_o, 8'h02);
      if (c == 10) chk("t4_stim2", bus.stim_o, 8'h04);
      if (c == 12) begin
        chk("t4_done_early", bus.done, 1'b0);
        bus.start = 1'b1;          // same edge that enters DONE
      end
    end
    chk("t4_done", bus.done, 1'b1);
    chk("t4_pass", bus.pass, 1'b1);
    tick();
    chk("t4_stay_done", bus.done, 1'b1);
    chk("t4_stay_idle", bus.busy, 1'b0);
    $display("run t4: num=3 err=%0d pass=%0d", bus.err_count, bus.pass);

    // Test 5: async reset in vector 3 of 10, then identical restart
    mode = 1;
    pulse_start(16'd10, 8'h01);
    repeat (15) tick();            // vector 3 (08) driven, now in SETTLE
    chk("t5_mid_stim", bus.stim_o, 8'h08);
    chk("t5_mid_err", bus.err_count, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_stim", bus.stim_o, 8'h00);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_err", bus.err_count, 16'd0);
    chk("t5_rst_first_in", bus.first_err_in, 8'h00);
    chk("t5_rst_done", bus.done, 1'b0);
    #2 rst = 1'b0;
    mode = 0;
    tick();
    pulse_start(16'd10, 8'h01);
    run_vectors(10, "t5");
    chk("t5_pass", bus.pass, 1'b1);

    // Test 6: ERR_W=2 saturation against an always-wrong DUT
    bus_s.num_vectors = 16'd6;
    bus_s.seed        = 8'h01;
    bus_s.start       = 1'b1;
    tick();
    bus_s.start = 1'b0;
    repeat (24) tick();
    chk("t6_done_early", bus_s.done, 1'b0);
    tick();
    chk("t6_done", bus_s.done, 1'b1);
    chk("t6_err_sat", bus_s.err_count, 2'd3);
    chk("t6_pass", bus_s.pass, 1'b0);
    chk("t6_first_idx", bus_s.first_err_idx, 16'd0);
    chk("t6_first_in", bus_s.first_err_in, 8'h01);
    chk("t6_first_out", bus_s.first_err_out, 8'h7F);
    $display("run t6: num=6 err=%0d pass=%0d", bus_s.err_count, bus_s.pass);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
